// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the ed25519 multiplier scheduler.
package mult_sched_pkg;
    localparam int W = 256;
    localparam logic [W-1:0] P = (256'd1 << 255) - 256'd19;
    // Cycles of post-reset drain beyond the multiplier's minimum latency.
    localparam int SETTLE_EXTRA = 8;

    typedef enum logic [2:0] {
        ST_DRAIN,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;
endpackage

// File: rtl/mult_sched_25519_if.sv
// Requester-side handshake bundle: operand requests in, reduced products out.
interface mult_sched_25519_if #(
    parameter int NREQ = 4
);
    import mult_sched_pkg::*;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   resp_valid;
    logic [W-1:0]      resp_data;
    logic              resp_err;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/rr_arbiter_onehot.sv
// Combinational round-robin arbiter: the first asserted request at or after ptr wins.
module rr_arbiter_onehot #(
    parameter  int NREQ = 4,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            any
);
    logic [PW-1:0] cand [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [PW:0] sum;
            assign sum       = {1'b0, ptr} + (PW+1)'(gi);
            assign cand[gi]  = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ)) : PW'(sum);
            assign grant[gi] = any && (idx == PW'(gi));
        end
    endgenerate

    // Scan from the far end so the candidate closest to ptr is written last.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                idx = cand[k];
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mult_sched_25519.sv
// Round-robin scheduler sharing one sequential mod-(2^255-19) multiplier among NREQ requesters.
module mult_sched_25519
    import mult_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MIN_LAT = 258,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    mult_sched_25519_if.slave bus,
    output logic              busy,
    output logic              mul_start,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic [W-1:0]      mul_product,
    input  logic              mul_done
);
    localparam int PW     = $clog2(NREQ);
    localparam int SETTLE = MIN_LAT + SETTLE_EXTRA;
    localparam int CMAX   = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
    localparam int CW     = $clog2(CMAX + 1);
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    state_t          state_reg;
    logic [PW-1:0]   ptr_reg;
    logic [PW-1:0]   g_reg;
    logic [CW-1:0]   cnt_reg;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    resp_data_reg;
    logic            resp_err_reg;
    logic            mul_start_reg;
    logic [NREQ-1:0] resp_valid_reg;

    logic [W-1:0]    a_arr [NREQ];
    logic [W-1:0]    b_arr [NREQ];
    logic [NREQ-1:0] grant;
    logic [PW-1:0]   grant_idx;
    logic            grant_any;
    logic            take;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = bus.req_a[gi*W +: W];
            assign b_arr[gi] = bus.req_b[gi*W +: W];
        end
    endgenerate

    rr_arbiter_onehot #(.NREQ(NREQ)) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr_reg),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    assign take           = (state_reg == ST_IDLE) && grant_any;
    assign bus.req_ready  = {NREQ{state_reg == ST_IDLE}} & grant;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_data  = resp_data_reg;
    assign bus.resp_err   = resp_err_reg;
    assign busy           = (state_reg != ST_IDLE);
    assign mul_start      = mul_start_reg;
    assign mul_a          = a_reg;
    assign mul_b          = b_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_DRAIN;
            ptr_reg        <= '0;
            g_reg          <= '0;
            cnt_reg        <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            resp_data_reg  <= '0;
            resp_err_reg   <= 1'b0;
            mul_start_reg  <= 1'b0;
            resp_valid_reg <= '0;
        end else begin
            mul_start_reg  <= 1'b0;
            resp_valid_reg <= '0;
            unique case (state_reg)
                // Give a multiplier interrupted by reset time to finish before reuse.
                ST_DRAIN: begin
                    if (cnt_reg == CW'(SETTLE - 1)) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (take) begin
                        a_reg         <= a_arr[grant_idx];
                        b_reg         <= b_arr[grant_idx];
                        g_reg         <= grant_idx;
                        ptr_reg       <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                        mul_start_reg <= 1'b1;
                        state_reg     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_reg   <= '0;
                    state_reg <= ST_WAIT;
                end
                // mul_done may be a stale level, so it only counts after MIN_LAT.
                ST_WAIT: begin
                    if (cnt_reg >= CW'(MIN_LAT) && mul_done) begin
                        resp_data_reg  <= mul_product;
                        resp_err_reg   <= 1'b0;
                        resp_valid_reg <= ONE << g_reg;
                        state_reg      <= ST_RESP;
                    end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                        resp_data_reg  <= '0;
                        resp_err_reg   <= 1'b1;
                        resp_valid_reg <= ONE << g_reg;
                        state_reg      <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_RESP: state_reg <= ST_IDLE;
                default: state_reg <= ST_DRAIN;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_sched_25519.sv
// Directed bench for mult_sched_25519 with a behavioural mod-P multiplier stub.
module tb_mult_sched_25519;
    import mult_sched_pkg::*;

    localparam int NREQ     = 4;
    localparam int MIN_LAT  = 258;
    localparam int TIMEOUT  = 1024;
    localparam int SETTLE   = MIN_LAT + SETTLE_EXTRA;
    localparam int STUB_LAT = 260;
    localparam int RESP_LAT = STUB_LAT + 1;

    logic         clk;
    logic         rst;
    logic         busy;
    logic         mul_start;
    logic [W-1:0] mul_a;
    logic [W-1:0] mul_b;
    logic [W-1:0] mul_product;
    logic         mul_done;

    mult_sched_25519_if #(.NREQ(NREQ)) bus ();

    mult_sched_25519 #(.NREQ(NREQ), .MIN_LAT(MIN_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product),
        .mul_done    (mul_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stub multiplier: 0 = level done at STUB_LAT, 1 = bogus early pulse too, 2 = never done.
    int           mode = 0;
    logic [15:0]  sk = '0;
    logic [W-1:0] good_q = '0;

    function automatic logic [W-1:0] mod_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] f;
        logic [2*W-1:0] r;
        f = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r = f % {{W{1'b0}}, P};
        return r[W-1:0];
    endfunction

    always @(posedge clk) begin
        if (mul_start) begin
            sk     <= 16'd1;
            good_q <= mod_mul(mul_a, mul_b);
        end else if (sk != 16'd0 && sk != 16'hFFFF) begin
            sk <= sk + 16'd1;
        end
    end

    always_comb begin
        mul_done    = 1'b0;
        mul_product = 256'hDEAD_BEEF;
        if (sk >= 16'(STUB_LAT)) begin
            mul_product = good_q;
            mul_done    = (mode != 2);
        end else if (mode == 1 && sk == 16'd5) begin
            mul_done = 1'b1;
        end
    end

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    int              cyc = 0;
    int              start_cnt = 0;
    int              start_cyc = 0;
    int              resp_cnt = 0;
    int              resp_cyc = 0;
    logic [NREQ-1:0] last_grant = '0;
    logic [NREQ-1:0] resp_mask = '0;
    logic [W-1:0]    resp_val = '0;
    logic            resp_e = 1'b0;
    int              gq[$];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            last_grant = bus.req_valid & bus.req_ready;
            if (last_grant != '0) gq.push_back(oh_idx(last_grant));
            if (mul_start) begin
                start_cnt++;
                start_cyc = cyc;
            end
            if (bus.resp_valid != '0) begin
                resp_cnt++;
                resp_cyc  = cyc;
                resp_mask = bus.resp_valid;
                resp_val  = bus.resp_data;
                resp_e    = bus.resp_err;
                $display("[%0d] resp req=%0d err=%0b data=%0h", cyc, oh_idx(bus.resp_valid),
                         bus.resp_err, bus.resp_data);
            end
        end
    end

    int checks = 0;
    int failures = 0;
    bit hold = 1'b0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock step; granted requesters withdraw unless they are holding valid.
    task automatic step();
        @(posedge clk);
        #2;
        if (!hold) bus.req_valid = bus.req_valid & ~last_grant;
    endtask

    task automatic post(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        bus.req_valid[i]    = 1'b1;
    endtask

    task automatic wait_resp(input string tag);
        int n0;
        int k;
        n0 = resp_cnt;
        k  = 0;
        while (resp_cnt == n0 && k < 2000) begin
            step();
            k++;
        end
        check(tag, W'(resp_cnt != n0), W'(1));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] exp2 [NREQ];
    int           k;
    int           n;
    int           s0;
    int           rc;

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;

        @(negedge clk);
        check("rst_ready",      W'(bus.req_ready),  W'(0));
        check("rst_resp_valid", W'(bus.resp_valid), W'(0));
        check("rst_resp_err",   W'(bus.resp_err),   W'(0));
        check("rst_mul_start",  W'(mul_start),      W'(0));
        check("rst_busy",       W'(busy),           W'(1));
        check("rst_resp_data",  bus.resp_data,      W'(0));
        check("rst_mul_a",      mul_a,              W'(0));
        @(posedge clk);
        #2;
        rst = 1'b0;
        k = 0;
        while (busy && k < 1000) begin
            step();
            k++;
        end
        check("drain_done", W'(busy), W'(0));

        // Single request.
        s0 = start_cnt;
        post(1, W'(2), W'(3));
        wait_resp("t1_seen");
        check("t1_mask", W'(resp_mask), W'(4'b0010));
        check("t1_data", resp_val, W'(6));
        check("t1_err",  W'(resp_e), W'(0));
        check("t1_lat",  W'(resp_cyc - start_cyc), W'(RESP_LAT));
        repeat (5) step();
        check("t1_starts", W'(start_cnt - s0), W'(1));

        // Requester 3 brings ptr back to 0; (P-1)^2 reduces to 1.
        post(3, P - W'(1), P - W'(1));
        wait_resp("tp_seen");
        check("tp_mask", W'(resp_mask), W'(4'b1000));
        check("tp_data", resp_val, W'(1));

        // All four at once.
        gq.delete();
        exp2[0] = W'(12);
        exp2[1] = W'(100);
        exp2[2] = P - W'(2);
        exp2[3] = W'(19) << 45;
        post(0, W'(3), W'(4));
        post(1, W'(10), W'(10));
        post(2, P - W'(1), W'(2));
        post(3, W'(1) << 200, W'(1) << 100);
        for (int r = 0; r < NREQ; r++) begin
            wait_resp("t2_seen");
            check("t2_mask", W'(resp_mask), W'(NREQ'(1) << r));
            check("t2_data", resp_val, exp2[r]);
        end
        check("t2_ngrant", W'(gq.size()), W'(4));
        for (int r = 0; r < NREQ; r++)
            check("t2_order", W'((gq.size() > r) ? gq[r] : -1), W'(r));

        // Fairness between continuous requesters 0 and 3.
        gq.delete();
        hold = 1'b1;
        post(0, W'(7), W'(9));
        post(3, W'(4), W'(4));
        k = 0;
        while (gq.size() < 4 && k < 3000) begin
            step();
            k++;
        end
        bus.req_valid = '0;
        hold = 1'b0;
        wait_resp("t3_seen");
        check("t3_ngrant", W'(gq.size()), W'(4));
        for (int r = 0; r < 4; r++)
            check("t3_order", W'((gq.size() > r) ? gq[r] : -1), W'((r % 2 == 0) ? 0 : 3));
        check("t3_mask", W'(resp_mask), W'(4'b1000));
        check("t3_data", resp_val, W'(16));

        // Early bogus done must be ignored.
        mode = 1;
        post(2, W'(11), W'(13));
        wait_resp("t4_seen");
        check("t4_data", resp_val, W'(143));
        check("t4_err",  W'(resp_e), W'(0));
        check("t4_lat",  W'(resp_cyc - start_cyc), W'(RESP_LAT));
        mode = 0;

        // Hung multiplier times out, then service resumes.
        mode = 2;
        post(1, W'(5), W'(5));
        wait_resp("t5_seen");
        check("t5_mask", W'(resp_mask), W'(4'b0010));
        check("t5_err",  W'(resp_e), W'(1));
        check("t5_data", resp_val, W'(0));
        check("t5_lat",  W'(resp_cyc - start_cyc), W'(TIMEOUT + 1));
        mode = 0;
        post(1, W'(6), W'(7));
        wait_resp("t5b_seen");
        check("t5b_data", resp_val, W'(42));
        check("t5b_err",  W'(resp_e), W'(0));

        // Reset 100 cycles into WAIT.
        s0 = start_cnt;
        post(2, W'(9), W'(9));
        k = 0;
        while (start_cnt == s0 && k < 100) begin
            step();
            k++;
        end
        repeat (100) step();
        rc  = resp_cnt;
        rst = 1'b1;
        #1;
        check("t6_busy",      W'(busy),          W'(1));
        check("t6_ready",     W'(bus.req_ready), W'(0));
        check("t6_resp_data", bus.resp_data,     W'(0));
        check("t6_mul_a",     mul_a,             W'(0));
        post(0, W'(5), W'(7));
        step();
        step();
        rst = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready[0] && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check("t6_drain_len", W'(n), W'(SETTLE));
        step();
        wait_resp("t6_seen");
        check("t6_mask",  W'(resp_mask), W'(4'b0001));
        check("t6_data",  resp_val, W'(35));
        check("t6_nresp", W'(resp_cnt - rc), W'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
